goldschmidt_ctrl: RTL and testbench

GOLDSCHMIDT_CTRL -- requirements
Module: goldschmidt_ctrl

---
 rtl/goldschmidt_ctrl_pkg.sv | 17 +
 rtl/goldschmidt_ctrl_twos_comp8.sv | 9 +
 rtl/goldschmidt_ctrl.sv | 112 +++++++++++
 tb/tb_goldschmidt_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goldschmidt_ctrl_pkg.sv
// Shared types and constants for the Goldschmidt divider controller (package gs_pkg).
package gs_pkg;

  localparam int GS_W         = 8;
  localparam int GS_QW        = 9;
  localparam int GS_ITERS_MAX = 7;
  localparam int GS_CW        = $clog2(GS_ITERS_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    FACT,
    MUL,
    FIN,
    ERR
  } gs_state_t;

endpackage

// File: rtl/goldschmidt_ctrl_twos_comp8.sv
// Combinational 8-bit two's complement used to form the correction factor 2-D.
module twos_comp8 (
  input  logic [7:0] value,
  output logic [7:0] result
);

  assign result = ~value + 8'd1;

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Iterative Goldschmidt divider controller, Q0.8 / Q0.8 -> Q1.8.
// Define GS_ROUND_EN to round each product to nearest instead of truncating.
module goldschmidt_ctrl
  import gs_pkg::*;
#(
  parameter int ITERS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GS_W-1:0]  dividend,
  input  logic [GS_W-1:0]  divisor,
  output logic             busy,
  output logic             done,
  output logic [GS_QW-1:0] quotient,
  output logic             err
);

  localparam logic [GS_CW-1:0] LAST = GS_CW'(ITERS - 1);

`ifdef GS_ROUND_EN
  localparam logic [17:0] RND = 18'h00080;
`else
  localparam logic [17:0] RND = 18'h00000;
`endif

  gs_state_t        state;
  logic [GS_QW-1:0] n_q;
  logic [GS_W-1:0]  d_q;
  logic [GS_QW-1:0] f_q;
  logic [GS_CW-1:0] cnt;

  logic [GS_W-1:0]  d_neg;
  logic [17:0]      n_prod, n_scaled;
  logic [16:0]      d_prod, d_scaled;
  logic [GS_QW-1:0] n_next;
  logic [GS_W-1:0]  d_next;

  twos_comp8 u_comp (
    .value  (d_q),
    .result (d_neg)
  );

  // Products are Q2.16 (N) and Q1.16 (D); shifting by 8 returns to the register format.
  assign n_prod   = {9'd0, n_q} * {9'd0, f_q};
  assign d_prod   = {9'd0, d_q} * {8'd0, f_q};
  assign n_scaled = (n_prod + RND) >> 8;
  assign d_scaled = (d_prod + RND[16:0]) >> 8;
  assign n_next   = (n_scaled > 18'h001FF) ? 9'h1FF : n_scaled[8:0];
  assign d_next   = (d_scaled > 17'h000FF) ? 8'hFF  : d_scaled[7:0];

  // NOTE: every register here uses non-blocking assignment, so MUL reads the pre-update N and D.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      quotient <= '0;
      n_q      <= '0;
      d_q      <= '0;
      f_q      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!divisor[GS_W-1]) begin
              state <= ERR;
            end else begin
              n_q   <= {1'b0, dividend};
              d_q   <= divisor;
              cnt   <= '0;
              state <= FACT;
            end
          end
        end
        FACT: begin
          f_q   <= {1'b1, d_neg};
          state <= MUL;
        end
        MUL: begin
          n_q   <= n_next;
          d_q   <= d_next;
          cnt   <= cnt + 1'b1;
          state <= (cnt < LAST) ? FACT : FIN;
        end
        FIN: begin
          quotient <= n_q;
          done     <= 1'b1;
          err      <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          quotient <= '0;
          done     <= 1'b1;
          err      <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Scoreboard bench for goldschmidt_ctrl; a second instance with ITERS=7 covers the near-max case.
module tb_goldschmidt_ctrl;

  typedef struct {
    logic [8:0] q;
    logic       e;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, start7;
  logic [7:0] dividend, divisor;
  logic       busy, done, err;
  logic       busy7, done7, err7;
  logic [8:0] quotient, quotient7;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  goldschmidt_ctrl #(.ITERS(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .err      (err)
  );

  goldschmidt_ctrl #(.ITERS(7)) u_dut7 (
    .clk      (clk),
    .rst      (rst),
    .start    (start7),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy7),
    .done     (done7),
    .quotient (quotient7),
    .err      (err7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: N and D multiplied by F = 2 - D each iteration, in plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] n0, input logic [7:0] d0, input int iters);
    exp_t r;
    int n, d, f, pn, pd, rn, rd;
    r.q  = 9'h000;
    r.e  = 1'b0;
    r.at = 2 * iters + 1;
    if (!d0[7]) begin
      r.e  = 1'b1;
      r.at = 1;
      return r;
    end
    n = int'(n0);
    d = int'(d0);
    for (int i = 0; i < iters; i++) begin
      f  = 512 - d;
      pn = n * f;
      pd = d * f;
      rn = pn / 256;
      rd = pd / 256;
`ifdef GS_ROUND_EN
      rn = rn + ((pn / 128) % 2);
      rd = rd + ((pd / 128) % 2);
`endif
      n = (rn > 511) ? 511 : rn;
      d = (rd > 255) ? 255 : rd;
    end
    r.q = 9'(n);
    return r;
  endfunction

  // Caller is at a negedge; start is held for one rising edge.
  task automatic issue(input logic [7:0] n, input logic [7:0] d);
    exp_t x;
    x    = model(n, d, 3);
    x.at = cyc + 1 + x.at;
    sb.push_back(x);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input string name);
    exp_t x;
    int   waited = 0;
    while (done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, waited);
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: done=1 with no division outstanding, required no done", name);
      return;
    end
    x = sb.pop_front();
    checks++;
    if (quotient !== x.q) begin
      errors++;
      $display("FAIL %s quotient: got %h required %h", name, quotient, x.q);
    end
    checks++;
    if (err !== x.e) begin
      errors++;
      $display("FAIL %s err: got %b required %b", name, err, x.e);
    end
    checks++;
    if (cyc != x.at) begin
      errors++;
      $display("FAIL %s latency: done at cycle %0d required %0d", name, cyc, x.at);
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start    = 1'b1;
    start7   = 1'b0;
    dividend = 8'h80;
    divisor  = 8'h80;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: busy=%b done=%b err=%b required 0 0 0", busy, done, err);
    end
    checks++;
    if (quotient !== 9'h000) begin
      errors++;
      $display("FAIL reset quotient: got %h required 000", quotient);
    end
    checks++;
    if (u_dut.n_q !== 9'h000) begin
      errors++;
      $display("FAIL reset n_q: got %h required 000 (start must not load during reset)", u_dut.n_q);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    issue(8'h80, 8'h80);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic busy: got %b required 1", busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (u_dut.n_q !== 9'h0C0) begin
      errors++;
      $display("FAIL basic n_iter1: got %h required 0C0", u_dut.n_q);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (u_dut.n_q !== 9'h0F0) begin
      errors++;
      $display("FAIL basic n_iter2: got %h required 0F0", u_dut.n_q);
    end
    collect("basic");
    @(negedge clk);
  endtask

  task automatic test_illegal;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal busy_before: got %b required 0", busy);
    end
    issue(8'h55, 8'h40);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL illegal busy_during: got %b required 1", busy);
    end
    collect("illegal");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal busy_after: got %b required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_dividend;
    issue(8'h00, 8'hA3);
    collect("zero_dividend");
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    int         base;
    logic [8:0] held;
    base = done_cnt;
    held = model(8'h90, 8'hC0, 3).q;
    issue(8'h90, 8'hC0);
    repeat (2) @(negedge clk);
    dividend = 8'h11;
    divisor  = 8'h81;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'hFF;
    divisor  = 8'h10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("start_busy");
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL start_busy done_count: got %0d required 1", done_cnt - base);
    end
    checks++;
    if (quotient !== held) begin
      errors++;
      $display("FAIL start_busy hold: got %h required %h", quotient, held);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    base     = done_cnt;
    dividend = 8'hFF;
    divisor  = 8'h80;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid flags: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (quotient !== 9'h000) begin
      errors++;
      $display("FAIL reset_mid quotient: got %h required 000", quotient);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt != base) begin
      errors++;
      $display("FAIL reset_mid done_count: got %0d required 0", done_cnt - base);
    end
    issue(8'hC8, 8'h9A);
    collect("reset_mid_restart");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(8'h40, 8'hE0);
    collect("b2b_first");
    issue(8'hB7, 8'h85);
    collect("b2b_second");
    issue(8'h01, 8'hFF);
    collect("b2b_third");
    @(negedge clk);
  endtask

  task automatic test_near_max;
    exp_t x;
    int   waited = 0;
    issue(8'hFF, 8'h80);
    collect("near_max_iters3");
    @(negedge clk);
    x        = model(8'hFF, 8'h80, 7);
    x.at     = cyc + 1 + x.at;
    dividend = 8'hFF;
    divisor  = 8'h80;
    start7   = 1'b1;
    @(negedge clk);
    start7 = 1'b0;
    while (done7 !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (done7 !== 1'b1) begin
      errors++;
      $display("FAIL near_max_iters7: done=%b after %0d cycles, required 1", done7, waited);
      return;
    end
    checks++;
    if (quotient7 !== x.q || err7 !== 1'b0) begin
      errors++;
      $display("FAIL near_max_iters7 result: got %h err %b required %h err 0", quotient7, err7, x.q);
    end
    checks++;
    if (quotient7 < 9'h1FC) begin
      errors++;
      $display("FAIL near_max_iters7 range: got %h required 1FC..1FF", quotient7);
    end
    checks++;
    if (cyc != x.at) begin
      errors++;
      $display("FAIL near_max_iters7 latency: done at cycle %0d required %0d", cyc, x.at);
    end
    @(negedge clk);
    checks++;
    if (busy7 !== 1'b0) begin
      errors++;
      $display("FAIL near_max_iters7 busy: got %b required 0", busy7);
    end
  endtask

  task automatic test_random;
    logic [7:0] n, d;
    for (int i = 0; i < 6; i++) begin
      n = 8'($urandom_range(0, 255));
      d = (i == 5) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      issue(n, d);
      collect("random");
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_zero_dividend();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_near_max();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d results outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
